// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back path.
//   XLEN   : data width of a register
//   REG_AW : register address width
//   NREGS  : number of architectural registers
//   wb_entry_t : one pending write (destination + data)
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef struct packed {
        logic [REG_AW-1:0] wr;
        logic [XLEN-1:0]   din;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_writer_if.sv
// Bundle of the write-back driver's bus signals.
//   primary   : p_valid, p_wr, p_din               (pipeline -> writer, no backpressure)
//   secondary : s_valid, s_wr, s_din / s_ready     (long-latency units <-> writer)
//   regfile   : we, wr, din                        (writer -> register file)
//   hazard    : pend_mask, stall_req, fifo_count   (writer -> hazard unit)
// The slave modport is the writer itself; the master modport is its environment.
interface regfile_wb_writer_if
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);

    logic                    p_valid;
    logic [REG_AW-1:0]       p_wr;
    logic [XLEN-1:0]         p_din;

    logic                    s_valid;
    logic                    s_ready;
    logic [REG_AW-1:0]       s_wr;
    logic [XLEN-1:0]         s_din;

    logic                    we;
    logic [REG_AW-1:0]       wr;
    logic [XLEN-1:0]         din;

    logic [NREGS-1:0]        pend_mask;
    logic                    stall_req;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport slave (
        input  p_valid, p_wr, p_din,
        input  s_valid, s_wr, s_din,
        output s_ready,
        output we, wr, din,
        output pend_mask, stall_req, fifo_count
    );

    modport master (
        output p_valid, p_wr, p_din,
        output s_valid, s_wr, s_din,
        input  s_ready,
        input  we, wr, din,
        input  pend_mask, stall_req, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for secondary write-back results.
//   clk, rst_n      : clock, asynchronous active-low reset (contents discarded)
//   push_i, entry_i : enqueue request and data (ignored when full)
//   pop_i           : dequeue request (ignored when empty)
//   head_o          : entry at the read pointer
//   count_o         : occupied entries; full_o / empty_o derived from it
//   pend_mask_o     : one bit per register targeted by any valid entry
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [NREGS-1:0] pend_mask_o
);

    wb_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic               push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            count_q <= count_d;
            // Push and pop never touch the same slot: that needs full or empty,
            // and the matching side is blocked in both cases.
            if (push_ok) begin
                wr_ptr_q          <= wr_ptr_q + 1'b1;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q          <= rd_ptr_q + 1'b1;
                valid_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    // Data storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pend_mask_o[mem_q[i].wr] = 1'b1;
            end
        end
        pend_mask_o[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_wb_writer.sv
// Write-back port driver for the 32x32 register file.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of regfile_wb_writer_if
//                primary result (wins arbitration), secondary result via FIFO,
//                registered we/wr/din to the register file, pend_mask /
//                stall_req / fifo_count to the hazard unit.
// Primary results with p_wr=0 and secondary results with s_wr=0 are dropped so
// register 0 is never written.
module regfile_wb_writer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_writer_if.slave    bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    logic              p_live;
    logic              s_push;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    wb_entry_t         head;
    wb_entry_t         s_entry;

    logic              we_q, we_d;
    logic [REG_AW-1:0] wr_q, wr_d;
    logic [XLEN-1:0]   din_q, din_d;
    logic [StW-1:0]    starve_q, starve_d;
    logic              stall_q, stall_d;

    assign p_live  = bus.p_valid & (bus.p_wr != '0);
    // s_ready comes from the registered count only, so a same-edge pop at
    // full does not open a slot for that edge's push.
    assign s_push  = bus.s_valid & ~fifo_full & (bus.s_wr != '0);
    assign pop     = ~p_live & ~fifo_empty;
    assign s_entry = '{wr: bus.s_wr, din: bus.s_din};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (s_push),
        .entry_i     (s_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .pend_mask_o (bus.pend_mask)
    );

    always_comb begin
        we_d  = 1'b0;
        wr_d  = wr_q;
        din_d = din_q;
        if (p_live) begin
            we_d  = 1'b1;
            wr_d  = bus.p_wr;
            din_d = bus.p_din;
        end else if (pop) begin
            we_d  = 1'b1;
            wr_d  = head.wr;
            din_d = head.din;
        end
    end

    // A non-empty FIFO that does not pop has necessarily lost to a live primary.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != StW'(STARVE_MAX)) begin
            starve_d = starve_q + StW'(1);
        end
        stall_d = (starve_d == StW'(STARVE_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            wr_q     <= '0;
            din_q    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_d;
            wr_q     <= wr_d;
            din_q    <= din_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.we         = we_q;
    assign bus.wr         = wr_q;
    assign bus.din        = din_q;
    assign bus.stall_req  = stall_q;
    assign bus.s_ready    = ~fifo_full;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed bench for regfile_wb_writer. Expected register-file writes are
// queued by the stimulus in hand-computed order; a negedge monitor pops and
// compares every cycle with we=1. Status outputs are checked directly.
module tb_regfile_wb_writer;
    import wb_pkg::*;

    logic clk;
    logic rst_n;

    regfile_wb_writer_if #(.DEPTH(4)) bus ();

    regfile_wb_writer #(
        .DEPTH      (4),
        .STARVE_MAX (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int        n_checks = 0;
    int        n_fail   = 0;
    wb_entry_t exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back('{wr: r, din: d});
    endtask

    task automatic drive(input logic pv, input logic [4:0] pw, input logic [31:0] pd,
                         input logic sv, input logic [4:0] sw, input logic [31:0] sd);
        bus.p_valid = pv;
        bus.p_wr    = pw;
        bus.p_din   = pd;
        bus.s_valid = sv;
        bus.s_wr    = sw;
        bus.s_din   = sd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write seen by the register file must match the queue head.
    always @(negedge clk) begin
        if (bus.we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got wr=%0d din=0x%0h, expected no write",
                         bus.wr, bus.din);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                check("wb_write", {27'd0, bus.wr, bus.din}, {27'd0, e.wr, e.din});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        check("rst_we",         64'(bus.we),         64'(0));
        check("rst_wr",         64'(bus.wr),         64'(0));
        check("rst_din",        64'(bus.din),        64'(0));
        check("rst_count",      64'(bus.fifo_count), 64'(0));
        check("rst_pend",       64'(bus.pend_mask),  64'(0));
        check("rst_stall",      64'(bus.stall_req),  64'(0));
        check("rst_s_ready",    64'(bus.s_ready),    64'(1));
        #10 rst_n = 1'b1;
        step();

        // Primary only.
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'h1234);
        step();
        idle();
        check("prim_we",        64'(bus.we),         64'(1));
        check("prim_wr",        64'(bus.wr),         64'(5));
        check("prim_din",       64'(bus.din),        64'(32'h1234));
        step();
        check("idle_we",        64'(bus.we),         64'(0));
        check("idle_hold_din",  64'(bus.din),        64'(32'h1234));

        // Secondary through the idle path.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD);
        expect_wr(5'd9, 32'hDEAD);
        step();
        idle();
        check("sec_pend",       64'(bus.pend_mask),  64'(32'h200));
        check("sec_count",      64'(bus.fifo_count), 64'(1));
        check("sec_no_bypass",  64'(bus.we),         64'(0));
        step();
        check("sec_we",         64'(bus.we),         64'(1));
        check("sec_wr",         64'(bus.wr),         64'(9));
        check("sec_pend_clr",   64'(bus.pend_mask),  64'(0));

        // Fill under a live primary every cycle; starvation trips on the 4th.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(1 + i), 32'h100 + 32'(i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            expect_wr(5'(1 + i), 32'h100 + 32'(i));
            step();
            if (i == 2) check("fill_stall_early", 64'(bus.stall_req), 64'(0));
        end
        for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'hA0 + 32'(i));
        expect_wr(5'd15, 32'hF5);
        check("full_count",     64'(bus.fifo_count), 64'(4));
        check("full_s_ready",   64'(bus.s_ready),    64'(0));
        check("full_pend",      64'(bus.pend_mask),  64'(32'h3C00));
        check("full_stall",     64'(bus.stall_req),  64'(1));
        // Fifth push offered while full: held, not lost.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF5);
        step();
        check("pop_full_count", 64'(bus.fifo_count), 64'(3));
        check("pop_full_stall", 64'(bus.stall_req),  64'(0));
        check("pop_full_ready", 64'(bus.s_ready),    64'(1));
        step();
        idle();
        check("pushpop_count",  64'(bus.fifo_count), 64'(3));
        check("pushpop_pend",   64'(bus.pend_mask),  64'(32'hB000));
        step();
        step();
        step();
        check("drain_count",    64'(bus.fifo_count), 64'(0));
        check("drain_pend",     64'(bus.pend_mask),  64'(0));

        // Starvation with a single queued entry.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(1 + i), 32'h11 * 32'(i + 1), 1'b0, 5'd0, 32'd0);
            expect_wr(5'(1 + i), 32'h11 * 32'(i + 1));
            step();
            if (i == 1) check("starve_stall_early", 64'(bus.stall_req), 64'(0));
        end
        expect_wr(5'd7, 32'h77);
        idle();
        check("starve_stall",   64'(bus.stall_req),  64'(1));
        check("starve_pend",    64'(bus.pend_mask),  64'(32'h80));
        step();
        check("starve_pop_wr",  64'(bus.wr),         64'(7));
        check("starve_release", 64'(bus.stall_req),  64'(0));

        // Zero-register handling.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
        expect_wr(5'd3, 32'h33);
        step();
        drive(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBEEF);
        #1;
        check("zero_s_ready",   64'(bus.s_ready),    64'(1));
        step();
        check("zero_pop_we",    64'(bus.we),         64'(1));
        check("zero_pop_din",   64'(bus.din),        64'(32'h33));
        check("zero_count",     64'(bus.fifo_count), 64'(0));
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
        step();
        idle();
        check("zero_s_count",   64'(bus.fifo_count), 64'(0));
        check("zero_s_we",      64'(bus.we),         64'(0));

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b1, 5'(4 + i), 32'h40 + 32'(i));
            // The last primary is in flight when reset hits and must not complete.
            if (i < 2) expect_wr(5'(20 + i), 32'h200 + 32'(i));
            step();
        end
        idle();
        check("pre_rst_count",  64'(bus.fifo_count), 64'(3));
        check("pre_rst_pend",   64'(bus.pend_mask),  64'(32'h70));
        #1 rst_n = 1'b0;
        #1;
        check("arst_we",        64'(bus.we),         64'(0));
        check("arst_count",     64'(bus.fifo_count), 64'(0));
        check("arst_pend",      64'(bus.pend_mask),  64'(0));
        check("arst_s_ready",   64'(bus.s_ready),    64'(1));
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        step();
        step();
        check("post_rst_we",    64'(bus.we),         64'(0));
        check("writes_pending", 64'(exp_q.size()),   64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
